// File: rtl/codes.sv
// rtl/codes.sv - shared CPU codes: sequencer states and sequencer defaults
package codes;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    EXEC1 = 3'd1,
    EXEC2 = 3'd2,
    HALT  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_0000;
  localparam int unsigned DEFAULT_MAX_WAIT  = 255;

  // HALT and FAULT are terminal; control drives all write-enables low there
  function automatic logic is_running(input state_t s);
    return (s == FETCH) || (s == EXEC1) || (s == EXEC2);
  endfunction

endpackage

// File: rtl/state_sequencer_wait_watchdog.sv
// rtl/state_sequencer_wait_watchdog.sv - consecutive-stall counter with expiry compare
module wait_watchdog (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic [31:0] limit_i,
  output logic        expire_o
);

  logic [31:0] wait_q;

  always_ff @(posedge clk) begin
    if (reset || !stall_i) begin
      wait_q <= 32'd0;
    end else if (wait_q != 32'hFFFF_FFFF) begin
      wait_q <= wait_q + 32'd1;
    end
  end

  // A zero limit disables the watchdog entirely
  assign expire_o = stall_i && (limit_i != 32'd0) && (wait_q == limit_i - 32'd1);

endmodule

// File: rtl/state_sequencer.sv
// rtl/state_sequencer.sv - FETCH/EXEC1/EXEC2 sequencer with halt, watchdog; SEQ_PERF_CNT_EN adds counters
module state_sequencer
  import codes::*;
#(
  parameter logic [31:0] HALT_ADDR = DEFAULT_HALT_ADDR,
  parameter int unsigned MAX_WAIT  = DEFAULT_MAX_WAIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest_i,
  input  logic        mem_access_i,
  input  logic [31:0] pc_next_i,
  output state_t      state_o,
  output logic        active_o,
  output logic        stall_o,
  output logic        fault_o,
  output logic [31:0] instr_count_o,
  output logic [31:0] stall_count_o
);

  state_t state_q;
  logic   active_q;
  logic   fault_q;
  logic   running;
  logic   expire;

  assign running = is_running(state_q);
  assign stall_o = running && mem_access_i && waitrequest_i;

  wait_watchdog u_wait_watchdog (
    .clk      (clk),
    .reset    (reset),
    .stall_i  (stall_o),
    .limit_i  (32'(MAX_WAIT)),
    .expire_o (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      active_q <= 1'b1;
      fault_q  <= 1'b0;
    end else if (running) begin
      if (stall_o) begin
        if (expire) begin
          state_q  <= FAULT;
          active_q <= 1'b0;
          fault_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          FETCH: state_q <= EXEC1;
          EXEC1: state_q <= EXEC2;
          EXEC2: begin
            if (pc_next_i == HALT_ADDR) begin
              state_q  <= HALT;
              active_q <= 1'b0;
            end else begin
              state_q <= FETCH;
            end
          end
          default: state_q <= state_q;
        endcase
      end
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instr_count_q;
  logic [31:0] stall_count_q;

  // The halting instruction still retires: it is a non-stalled EXEC2 cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else if (running) begin
      if (stall_o) begin
        stall_count_q <= stall_count_q + 32'd1;
      end else if (state_q == EXEC2) begin
        instr_count_q <= instr_count_q + 32'd1;
      end
    end
  end

  assign instr_count_o = instr_count_q;
  assign stall_count_o = stall_count_q;
`else
  assign instr_count_o = 32'd0;
  assign stall_count_o = 32'd0;
`endif

  assign state_o  = state_q;
  assign active_o = active_q;
  assign fault_o  = fault_q;

endmodule

// File: tb/tb_state_sequencer.sv
// tb/tb_state_sequencer.sv - randomized and directed bench against a behavioural sequencer model
module tb_state_sequencer;
  import codes::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        waitrequest;
  logic        mem_access;
  logic [31:0] pc_next;

  state_t      st_a, st_b;
  logic        act_a, act_b, stl_a, stl_b, flt_a, flt_b;
  logic [31:0] ic_a, ic_b, sc_a, sc_b;

  always #5 clk = ~clk;

  state_sequencer #(.HALT_ADDR(32'h0), .MAX_WAIT(255)) dut_a (
    .clk(clk), .reset(reset), .waitrequest_i(waitrequest), .mem_access_i(mem_access),
    .pc_next_i(pc_next), .state_o(st_a), .active_o(act_a), .stall_o(stl_a),
    .fault_o(flt_a), .instr_count_o(ic_a), .stall_count_o(sc_a)
  );

  state_sequencer #(.HALT_ADDR(32'h0), .MAX_WAIT(4)) dut_b (
    .clk(clk), .reset(reset), .waitrequest_i(waitrequest), .mem_access_i(mem_access),
    .pc_next_i(pc_next), .state_o(st_b), .active_o(act_b), .stall_o(stl_b),
    .fault_o(flt_b), .instr_count_o(ic_b), .stall_count_o(sc_b)
  );

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  // Model: instruction phase 0..2, terminal flags, run length of current stall streak
  int          m_phase  [2];
  bit          m_halted [2];
  bit          m_faulted[2];
  int          m_streak [2];
  logic [31:0] m_ic     [2];
  logic [31:0] m_sc     [2];
  int          m_limit  [2] = '{255, 4};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic state_t exp_state(input int k);
    if (m_faulted[k]) return FAULT;
    if (m_halted[k]) return HALT;
    if (m_phase[k] == 0) return FETCH;
    if (m_phase[k] == 1) return EXEC1;
    return EXEC2;
  endfunction

  function automatic bit m_running(input int k);
    return !m_halted[k] && !m_faulted[k];
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit          run = m_running(k);
      bit          stl = run && mem_access && waitrequest;
      logic [31:0] eic, esc;
`ifdef SEQ_PERF_CNT_EN
      eic = m_ic[k];
      esc = m_sc[k];
`else
      eic = 32'd0;
      esc = 32'd0;
`endif
      check_eq($sformatf("state%0d", k), 32'(k ? st_b : st_a), 32'(exp_state(k)));
      check_eq($sformatf("active%0d", k), 32'(k ? act_b : act_a), 32'(run));
      check_eq($sformatf("fault%0d", k), 32'(k ? flt_b : flt_a), 32'(m_faulted[k]));
      check_eq($sformatf("stall%0d", k), 32'(k ? stl_b : stl_a), 32'(stl));
      check_eq($sformatf("icount%0d", k), k ? ic_b : ic_a, eic);
      check_eq($sformatf("scount%0d", k), k ? sc_b : sc_a, esc);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_phase[k] = 0; m_halted[k] = 0; m_faulted[k] = 0;
        m_streak[k] = 0; m_ic[k] = 0; m_sc[k] = 0;
      end else if (m_running(k)) begin
        if (mem_access && waitrequest) begin
          m_sc[k]++;
          m_streak[k]++;
          if (m_limit[k] != 0 && m_streak[k] == m_limit[k]) m_faulted[k] = 1;
        end else begin
          m_streak[k] = 0;
          if (m_phase[k] == 2) begin
            m_ic[k]++;
            if (pc_next == 32'h0) m_halted[k] = 1;
            else m_phase[k] = 0;
          end else begin
            m_phase[k]++;
          end
        end
      end else begin
        m_streak[k] = 0;
      end
    end
  endtask

  task automatic drive(input bit r, input bit m, input bit w, input logic [31:0] pc);
    @(negedge clk);
    reset = r; mem_access = m; waitrequest = w; pc_next = pc;
    #1;
    if (armed) check_all();
    @(posedge clk);
    model_step();
    armed = 1'b1;
  endtask

  initial begin
    reset = 1'b1; mem_access = 1'b0; waitrequest = 1'b0; pc_next = 32'h0;
    repeat (2) drive(1, 0, 0, 32'h0);

    // three clean instructions
    repeat (9) drive(0, 0, 0, 32'hBFC0_0004);
    // EXEC1 held by four stalled cycles
    drive(0, 0, 0, 32'hBFC0_0004);
    repeat (4) drive(0, 1, 1, 32'hBFC0_0004);
    drive(0, 0, 0, 32'hBFC0_0004);
    drive(0, 0, 0, 32'hBFC0_0004);
    drive(1, 0, 0, 32'h0);

    // halt, then input activity that must change nothing
    drive(0, 0, 0, 32'h0);
    drive(0, 0, 0, 32'h0);
    drive(0, 0, 0, 32'h0);
    repeat (6) drive(0, 1'($urandom), 1'($urandom), $urandom);
    drive(1, 1, 1, 32'h0);

    // held in FETCH: the MAX_WAIT=4 copy faults
    repeat (6) drive(0, 1, 1, 32'h1234);
    drive(1, 0, 0, 32'h0);

    // two three-cycle streaks separated by an advance never fault
    repeat (3) drive(0, 1, 1, 32'h8);
    drive(0, 0, 0, 32'h8);
    repeat (3) drive(0, 1, 1, 32'h8);
    drive(0, 0, 0, 32'h8);

    // reset mid-stall forgets the streak
    repeat (3) drive(0, 1, 1, 32'h8);
    drive(1, 1, 1, 32'h8);
    repeat (3) drive(0, 1, 1, 32'h8);
    drive(0, 0, 0, 32'h8);

    for (int i = 0; i < 3000; i++) begin
      bit          r  = ($urandom_range(0, 39) == 0);
      bit          m  = 1'($urandom);
      bit          w  = ($urandom_range(0, 2) != 0);
      logic [31:0] pc = ($urandom_range(0, 19) == 0) ? 32'h0 : $urandom;
      drive(r, m, w, pc);
    end
    drive(0, 0, 0, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/state_sequencer.md
# state_sequencer

Multicycle state sequencer for the MIPS CPU core. It produces the `state_t` value consumed by the control decoder and steps FETCH → EXEC1 → EXEC2 → FETCH. It stretches any state whose memory access is held off by `waitrequest` and detects program termination (jump to the halt address). It also guards against a hung memory bus with a wait watchdog, and optionally keeps retire and stall counters.

## Interface
- `HALT_ADDR`, default 32'h0000_0000: next-PC value that terminates execution.
- `MAX_WAIT`, default 255: consecutive stalled cycles that trigger FAULT. A value of 0 disables the watchdog.
- Clock and reset: one clock, `clk`; reset is synchronous and active-high, named `reset`.
- `clk` input 1: core clock.
- `reset` input 1: synchronous, active-high reset.
- `waitrequest_i` input 1: memory bus hold-off.
- `mem_access_i` input 1: current state issues a memory read or write (control's `ram_rds_o | ram_wen_o`).
- `pc_next_i` input 32: PC value to be written at the end of EXEC2.
- `state_o` output `state_t`: current sequencer state.
- `active_o` output 1: CPU running.
- `stall_o` output 1: current state held this cycle.
- `fault_o` output 1: watchdog expired.
- `instr_count_o` output 32: retired instructions.
- `stall_count_o` output 32: total stalled cycles.

## Operation
- States: FETCH, EXEC1, EXEC2, HALT, FAULT.
- Reset values:
  - `state_o` = FETCH
  - `active_o` = 1
  - `fault_o` = 0
  - `stall_o` = 0
  - both counters = 0
  - internal wait counter = 0
- Stall condition, combinational: `stall_o = mem_access_i & waitrequest_i`, only in FETCH/EXEC1/EXEC2. It is 0 in HALT and FAULT.
- In a running state with `stall_o = 1`:
  - state holds;
  - wait counter increments;
  - `stall_count_o` increments.
- In a running state with `stall_o = 0`:
  - FETCH → EXEC1, EXEC1 → EXEC2;
  - EXEC2 → HALT if `pc_next_i == HALT_ADDR`, otherwise EXEC2 → FETCH;
  - wait counter clears.
- Retire: `instr_count_o` increments on every non-stalled EXEC2 cycle, including the instruction that halts.
- Watchdog: if `MAX_WAIT != 0` and a stalled cycle occurs with wait counter == `MAX_WAIT - 1`:
  - next state is FAULT;
  - `fault_o` is set to 1 (registered).
  - With `MAX_WAIT = 1`, the first stalled cycle faults.
- HALT and FAULT are sticky until `reset`.
  - `active_o` = 0 in both.
  - Counters freeze.
  - `pc_next_i`, `waitrequest_i` and `mem_access_i` are ignored.
- Counters wrap at 2^32. The wait counter is 32 bits and saturates at its maximum.

## Timing
- Unstalled instruction takes exactly 3 cycles. Each stalled cycle adds 1 cycle to the state in which it occurs.
- `state_o`, `active_o`, `fault_o` and the counters are registered and update on the rising `clk` edge.
- `stall_o` is combinational from the current state and inputs (no registered latency).
- `active_o` falls in the first cycle in which `state_o` = HALT or FAULT.
- `reset` wins over every transition, including from HALT/FAULT. After reset, FETCH is presented in the next cycle.
- `reset` asserted during a stall clears the wait counter. No fault may be raised from pre-reset stall history.
- A stall and the halt condition in the same EXEC2 cycle: the stall wins. Halt is evaluated only on the non-stalled EXEC2 cycle, using `pc_next_i` from that cycle.

## Configuration
- `SEQ_PERF_CNT_EN`
- Defined:
  - `instr_count_o` and `stall_count_o` are implemented as described above.
- Undefined:
  - both counter registers are omitted and both outputs are tied to 0;
  - the wait counter and watchdog remain.

## Structure
- Shared package `codes`:
  - `state_t` gains HALT and FAULT alongside FETCH/EXEC1/EXEC2;
  - control treats HALT and FAULT as all write-enables 0.
- Also in `codes`: default localparams for halt address and max wait.
- One sub-module, `wait_watchdog`: wait counter plus the expiry compare.
  - Inputs: `clk`, `reset`, stall, limit.
  - Output: expire pulse.

## Test plan
- Reset, then 3 unstalled instructions with `pc_next_i` = 32'hBFC0_0004 → FETCH/EXEC1/EXEC2 repeats each 3 cycles; `instr_count_o` = 3 after 9 cycles; `active_o` = 1 throughout.
- `mem_access_i` = 1 and `waitrequest_i` = 1 for 4 cycles in EXEC1 → `state_o` holds EXEC1 for 5 cycles; `stall_o` = 1 for 4 of them; `stall_count_o` = 4; instruction completes in 7 cycles.
- EXEC2 with `pc_next_i` = 0 → next cycle `state_o` = HALT, `active_o` = 0, `instr_count_o` incremented. Subsequent input activity changes nothing.
- `MAX_WAIT` = 4, `waitrequest_i` held high in FETCH → FAULT after the 4th stalled cycle; `fault_o` = 1, `active_o` = 0.
- Stall for 3 cycles, release, stall 3 again with `MAX_WAIT` = 4 → no fault, since the wait counter cleared on advance.
- `reset` pulsed while in FAULT and mid-stall → `state_o` = FETCH, `fault_o` = 0, counters 0. Without `SEQ_PERF_CNT_EN`, both counter outputs read 0 throughout.
